// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the fetch stage.
package riscv_pkg;
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;
   localparam logic [XLEN-1:0] RESET_PC = 32'h00000000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry queue of fetched {pc, inst} pairs; flush beats push and pop.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           din,
   output logic                   full,
   output logic                   empty,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok, pop_ok;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   // A push into a full queue is only legal when the head leaves in the same cycle.
   always_comb begin
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC register, ROM addressing and redirect/flush control
// in front of the fetch queue that decode drains.
module instruction_fetch #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
   parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] Rom_addr,
   input  logic [31:0] Rom_data,
   input  logic        Halt,
   input  logic        Redirect_valid,
   input  logic [31:0] Redirect_pc,
   output logic        Inst_valid,
   input  logic        Inst_ready,
   output logic [31:0] Inst_data,
   output logic [31:0] Inst_pc
);

   import riscv_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [31:0]   pc_q, pc_d;
   logic          push, pop, q_full, q_empty;
   logic [CW-1:0] q_count;
   fetch_entry_t  q_din, q_head;

   assign Rom_addr = pc_q;
   assign q_din    = '{pc: pc_q, inst: Rom_data};

   // Redirect flushes the queue, so it suppresses both the push and any pop.
   always_comb begin
      pop  = Inst_valid & Inst_ready & ~Redirect_valid;
      push = ~Redirect_valid & ~Halt & (~q_full | pop);
      pc_d = pc_q;
      if (Redirect_valid)  pc_d = {Redirect_pc[31:2], 2'b00};
      else if (push)       pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (Redirect_valid),
      .din   (q_din),
      .full  (q_full),
      .empty (q_empty),
      .head  (q_head),
      .count (q_count)
   );

   // Head outputs depend only on registered queue state.
   assign Inst_valid = (q_count != '0);
   assign Inst_data  = q_empty ? NOP_INST : q_head.inst;
   assign Inst_pc    = q_empty ? 32'h0    : q_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a small combinational program ROM.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rom_addr, rom_data;
   logic        halt, redirect_valid, inst_ready;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_data, inst_pc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      case (a)
         32'h00:       rom_f = 32'hFE010113;
         32'h04:       rom_f = 32'h00112E23;
         32'h08:       rom_f = 32'h00812C23;
         32'h0C:       rom_f = 32'h02010413;
         32'h10:       rom_f = 32'h00000F93;
         32'h14:       rom_f = 32'h00100713;
         32'h18:       rom_f = 32'h00E7A023;
         32'h1C:       rom_f = 32'h000F8713;
         32'h20:       rom_f = 32'hFEC42783;
         32'h24:       rom_f = 32'h00178793;
         32'h44:       rom_f = 32'hFCDFF06F;
         32'hFFFFFFFC: rom_f = 32'h0000006F;
         default:      rom_f = 32'h00000013;
      endcase
   endfunction

   assign rom_data = rom_f(rom_addr);

   instruction_fetch #(.DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .Rom_addr       (rom_addr),
      .Rom_data       (rom_data),
      .Halt           (halt),
      .Redirect_valid (redirect_valid),
      .Redirect_pc    (redirect_pc),
      .Inst_valid     (inst_valid),
      .Inst_ready     (inst_ready),
      .Inst_data      (inst_data),
      .Inst_pc        (inst_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
      chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
      chk({tag, ".pc"},    inst_pc, pc);
      chk({tag, ".data"},  inst_data, inst);
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, ".valid"}, 32'(inst_valid), 32'd0);
      chk({tag, ".data"},  inst_data, 32'h00000013);
      chk({tag, ".pc"},    inst_pc, 32'h0);
   endtask

   initial begin
      rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      step(); step();
      chk_empty("reset");
      chk("reset.rom_addr", rom_addr, 32'h0);

      // streaming after reset release
      rst = 1'b0;
      step(); chk_head("t1.c1", 32'h0, 32'hFE010113);
      step(); chk_head("t1.c2", 32'h4, 32'h00112E23);
      step(); chk_head("t1.c3", 32'h8, 32'h00812C23);

      // backpressure fills the queue, then drains without gaps
      rst = 1'b1; inst_ready = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("t2.rom_addr_hold", rom_addr, 32'h8);
      chk_head("t2.full_head", 32'h0, 32'hFE010113);
      inst_ready = 1'b1;
      step(); chk_head("t2.d1", 32'h4, 32'h00112E23);
      step(); chk_head("t2.d2", 32'h8, 32'h00812C23);
      step(); chk_head("t2.d3", 32'hC, 32'h02010413);

      // redirect to misaligned target while full and popping
      redirect_valid = 1'b1; redirect_pc = 32'h1E;
      step(); chk("t3.valid0", 32'(inst_valid), 32'd0);
      chk("t3.rom_addr", rom_addr, 32'h1C);
      redirect_valid = 1'b0;
      step(); chk_head("t3.tgt", 32'h1C, 32'h000F8713);
      step(); chk_head("t3.next", 32'h20, 32'hFEC42783);

      // redirect to jal, then execute takes it back to 0x10
      redirect_valid = 1'b1; redirect_pc = 32'h44;
      step(); chk("t4.valid0", 32'(inst_valid), 32'd0);
      redirect_valid = 1'b0;
      step(); chk_head("t4.jal", 32'h44, 32'hFCDFF06F);
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      step(); chk("t4.valid0b", 32'(inst_valid), 32'd0);
      redirect_valid = 1'b0;
      step(); chk_head("t4.tgt10", 32'h10, 32'h00000F93);
      redirect_valid = 1'b1; redirect_pc = 32'h48;
      step();
      redirect_valid = 1'b0;
      step(); chk_head("t4.nop48", 32'h48, 32'h00000013);

      // halt drains the queue and freezes the PC
      inst_ready = 1'b0;
      step();
      chk("t5.rom_addr_pre", rom_addr, 32'h50);
      halt = 1'b1; inst_ready = 1'b1;
      step(); chk_head("t5.drain1", 32'h4C, 32'h00000013);
      step(); chk_empty("t5.empty");
      step(); chk("t5.rom_addr_frozen", rom_addr, 32'h50);
      chk("t5.valid_still0", 32'(inst_valid), 32'd0);
      halt = 1'b0;
      step(); chk_head("t5.resume", 32'h50, 32'h00000013);

      // PC wrap at the top of the address space
      redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
      step(); chk("wrap.rom_addr", rom_addr, 32'hFFFFFFFC);
      redirect_valid = 1'b0; inst_ready = 1'b0;
      step(); chk_head("wrap.head", 32'hFFFFFFFC, 32'h0000006F);
      chk("wrap.rom_addr0", rom_addr, 32'h0);

      // mid-stream reset with two entries queued
      step();
      chk_head("t6.full_head", 32'hFFFFFFFC, 32'h0000006F);
      rst = 1'b1; inst_ready = 1'b1;
      step(); chk_empty("t6.rst");
      chk("t6.rom_addr", rom_addr, 32'h0);
      rst = 1'b0;
      step(); chk_head("t6.restart", 32'h0, 32'hFE010113);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
